// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one single-port synchronous word RAM between an instruction
//           fetch port and a data port. One access is outstanding at a time.
//           Data wins ties, but a streak limit guarantees that fetch progresses.
//           Optional macro ARB_STAT_EN adds grant/conflict statistics outputs.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int WIDTH           = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [WIDTH-1:0]      if_addr,
  output logic [WIDTH-1:0]      if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WIDTH-1:0]      d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_valid,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
`ifdef ARB_STAT_EN
  ,
  output logic [31:0]           stat_if_grants,
  output logic [31:0]           stat_d_grants,
  output logic [31:0]           stat_conflicts
`endif
);

  localparam int CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  grant_d;
  logic                  grant_if;
  logic                  owner_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic [STREAK_W-1:0]   streak;
  logic [WIDTH-1:0]      if_rdata_q;
  logic [WIDTH-1:0]      d_rdata_q;
  logic                  resp_read;
  logic                  unused_addr_bits;

  // Only the word-address slice of the byte addresses reaches the RAM.
  assign unused_addr_bits = ^{if_addr, d_addr};

  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_req && (!if_req || (streak != STREAK_MAX))) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_d || grant_if) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q || (READ_LATENCY == 1)) begin
          next_state = S_RESP;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= CNT_W'(1)) begin
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      streak     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= next_state;

      if (grant_d || grant_if) begin
        owner_d <= grant_d;
        we_q    <= grant_d & d_we;
        addr_q  <= grant_d ? d_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
        wdata_q <= grant_d ? d_wdata : '0;
      end

      // Streak counts data grants that overtook a waiting fetch.
      if (state == S_IDLE) begin
        if (!if_req || grant_if) begin
          streak <= '0;
        end else if (grant_d && (streak != STREAK_MAX)) begin
          streak <= streak + STREAK_W'(1);
        end
      end

      if (state == S_ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      if (resp_read) begin
        if (owner_d) begin
          d_rdata_q <= mem_rdata;
        end else begin
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign resp_read = (state == S_RESP) && !we_q;

  assign busy      = (state != S_IDLE);
  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_valid  = (state == S_RESP) && !owner_d;
  assign d_valid   = (state == S_RESP) && owner_d;

  // Read data is forwarded straight from the RAM during the response cycle.
  assign if_rdata  = (resp_read && !owner_d) ? mem_rdata : if_rdata_q;
  assign d_rdata   = (resp_read && owner_d)  ? mem_rdata : d_rdata_q;

`ifdef ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (grant_if) begin
        stat_if_grants <= stat_if_grants + 32'd1;
      end
      if (grant_d) begin
        stat_d_grants <= stat_d_grants + 32'd1;
      end
      if ((state == S_IDLE) && if_req && d_req) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Testbench for mem_arbiter: directed scenarios against a 2-cycle-latency RAM model.
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic [WIDTH-1:0] if_rdata;
  logic             if_valid;
  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_valid;
  logic             busy;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
`ifdef ARB_STAT_EN
  logic [31:0]      stat_if_grants;
  logic [31:0]      stat_d_grants;
  logic [31:0]      stat_conflicts;
`endif

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(
    .WIDTH          (WIDTH),
    .ADDR_WIDTH     (AW),
    .READ_LATENCY   (2),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .busy     (busy),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_STAT_EN
    ,
    .stat_if_grants(stat_if_grants),
    .stat_d_grants (stat_d_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: read data appears two cycles after the mem_en cycle.
  logic [WIDTH-1:0] ram [0:1023];
  logic [WIDTH-1:0] rd_pipe0 = '0;
  logic [WIDTH-1:0] rd_pipe1 = '0;
  logic             bd_we = 1'b0;
  logic [AW-1:0]    bd_addr = '0;
  logic [WIDTH-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rd_pipe0 <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
    rd_pipe1 <= rd_pipe0;
  end
  assign mem_rdata = rd_pipe1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h40; d_wdata = 32'h0;
    tick();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_mem_en_c1: got %b expected 0", mem_en);
    end
    tick();
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h ifv=%b dv=%b ifr=%h dr=%h busy=%b expected all 0",
               mem_en, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata, busy);
    end
    rst = 1'b0;                       // cycle N: both requests pending
    tick();
    vectors++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h010}) begin
      miscompares++;
      $display("FAIL reset_first_grant: got en=%b we=%b addr=%h expected en=1 we=0 addr=010 (data)",
               mem_en, mem_we, mem_addr);
    end
    tick();
    tick();
    vectors++;
    if ({d_valid, if_valid} !== 2'b10) begin
      miscompares++; $display("FAIL reset_first_valid: got d=%b if=%b expected d=1 if=0", d_valid, if_valid);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({mem_en, busy, if_valid, d_valid} !== 4'b0000) begin
        miscompares++;
        $display("FAIL idle_quiet[%0d]: got en=%b busy=%b ifv=%b dv=%b expected all 0",
                 i, mem_en, busy, if_valid, d_valid);
      end
    end
  endtask

  task automatic test_fetch();
    bd_we = 1'b1; bd_addr = 10'd4; bd_data = 32'h0050_0093;
    tick();
    bd_we = 1'b0;
    if_addr = 32'h10; if_req = 1'b1;  // cycle N
    tick();
    vectors++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd4}) begin
      miscompares++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=004", mem_en, mem_we, mem_addr);
    end
    tick();
    vectors++;
    if ({if_valid, busy} !== 2'b01) begin
      miscompares++; $display("FAIL fetch_wait: got ifv=%b busy=%b expected ifv=0 busy=1", if_valid, busy);
    end
    tick();
    vectors++;
    if ({if_valid, d_valid, if_rdata} !== {1'b1, 1'b0, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL fetch_resp: got ifv=%b dv=%b data=%h expected ifv=1 dv=0 data=00500093", if_valid, d_valid, if_rdata);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if ({if_valid, busy, if_rdata} !== {1'b0, 1'b0, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL fetch_hold: got ifv=%b busy=%b data=%h expected ifv=0 busy=0 data=00500093", if_valid, busy, if_rdata);
    end
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd8, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL write_issue: got en=%b we=%b addr=%h wd=%h expected en=1 we=1 addr=008 wd=deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if ({d_valid, if_valid} !== 2'b10) begin
      miscompares++; $display("FAIL write_valid: got d=%b if=%b expected d=1 if=0", d_valid, if_valid);
    end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    tick();
    tick();
    tick();
    vectors++;
    if ({d_valid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL write_readback: got dv=%b data=%h expected dv=1 data=deadbeef", d_valid, d_rdata);
    end
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h1234_5678;
    tick();
    tick();
    vectors++;
    if ({d_valid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL write_keeps_rdata: got dv=%b data=%h expected dv=1 data=deadbeef", d_valid, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_streak();
    int got;
    logic is_if;
`ifdef ARB_STAT_EN
    logic [31:0] if0, d0, c0;
    if0 = stat_if_grants; d0 = stat_d_grants; c0 = stat_conflicts;
`endif
    got = 0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      tick();
      if (if_valid && d_valid) begin
        vectors++; miscompares++;
        $display("FAIL streak_both_valid: got if=1 d=1 expected at most one");
      end else if (if_valid || d_valid) begin
        is_if = (got % 5 == 4);
        vectors++;
        if (if_valid !== is_if) begin
          miscompares++;
          $display("FAIL streak_order[%0d]: got %s expected %s", got, if_valid ? "IF" : "D", is_if ? "IF" : "D");
        end
        vectors++;
        if ((if_valid ? if_rdata : d_rdata) !== (is_if ? 32'h0050_0093 : 32'hDEAD_BEEF)) begin
          miscompares++;
          $display("FAIL streak_data[%0d]: got if=%h d=%h", got, if_rdata, d_rdata);
        end
        got++;
        if (got == 10) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    vectors++;
    if (got != 10) begin
      miscompares++; $display("FAIL streak_timeout: got %0d grants expected 10", got);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
`ifdef ARB_STAT_EN
    vectors++;
    if ({stat_d_grants - d0, stat_if_grants - if0, stat_conflicts - c0} !== {32'd8, 32'd2, 32'd10}) begin
      miscompares++;
      $display("FAIL stat_counts: got d=%0d if=%0d conf=%0d expected d=8 if=2 conf=10",
               stat_d_grants - d0, stat_if_grants - if0, stat_conflicts - c0);
    end
`endif
  endtask

  task automatic test_reset_abort();
    if_req = 1'b1; if_addr = 32'h10;   // cycle N
    tick();
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++; $display("FAIL abort_issue: got en=%b expected 1", mem_en);
    end
    tick();                             // WAIT
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, if_valid, d_valid, if_rdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b ifv=%b dv=%b data=%h expected all 0", busy, if_valid, d_valid, if_rdata);
    end
    rst = 1'b0; if_addr = 32'h20;      // fresh request, cycle N'
    tick();
    vectors++;
    if ({mem_en, mem_addr, if_valid} !== {1'b1, 10'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_fresh_issue: got en=%b addr=%h ifv=%b expected en=1 addr=008 ifv=0", mem_en, mem_addr, if_valid);
    end
    tick();
    vectors++;
    if (if_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_early_valid: got %b expected 0", if_valid);
    end
    tick();
    vectors++;
    if ({if_valid, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL abort_fresh_resp: got ifv=%b data=%h expected ifv=1 data=deadbeef", if_valid, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fetch();
    test_write();
    test_streak();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
